// File: rtl/cdc_hs_tx_pkg.sv
// cdc_hs_tx_pkg: shared state encoding and counter width for the req/ack CDC sender.
package cdc_hs_tx_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;
  localparam int CNT_W = 16;
endpackage

// File: rtl/cdc_sync_2ff.sv
// cdc_sync_2ff: two-flop synchronizer for a single asynchronous bit.
module cdc_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_meta, r_q} <= 2'b00;
    else {r_meta, r_q} <= {i_d, r_meta};
  assign o_q = r_q;
endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: transmit side of a 4-phase req/ack bundled-data clock-domain crossing.
module cdc_hs_tx
  import cdc_hs_tx_pkg::*;
#(
  parameter int width   = 4,
  parameter int timeout = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             req_out,
  output logic [width-1:0] data_out,
  input  logic             ack_in,
  output logic             done,
  output logic             stall
);
  state_t             r_state, w_next;
  logic               r_req, r_done;
  logic [width-1:0]   r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_ack_s, w_accept, w_busy;
  cdc_sync_2ff u_sync (.clk(clk), .rst(rst), .i_d(ack_in), .o_q(w_ack_s));
  // Holding off during the done cycle keeps accept and done from coinciding.
  assign in_ready = (r_state == IDLE) && !w_ack_s && !r_done;
  assign w_accept = in_valid && in_ready;
  assign w_busy   = (r_state == REQ) || (r_state == REL);
  assign stall    = w_busy && (r_cnt == CNT_W'(timeout));
  assign req_out  = r_req;
  assign data_out = r_data;
  assign done     = r_done;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? SETUP : IDLE;
      SETUP:   w_next = REQ;
      REQ:     w_next = w_ack_s ? REL : REQ;
      REL:     w_next = w_ack_s ? REL : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= (r_state == REQ) && (w_next == REQ);
      r_done  <= (r_state == REL) && (w_next == IDLE);
      r_data  <= w_accept ? in_data : r_data;
      if ((w_next != r_state) && ((w_next == REQ) || (w_next == REL)))
        r_cnt <= '0;
      else if (w_busy && (r_cnt != CNT_W'(timeout)))
        r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed scoreboard bench for the CDC sender with an inline far-side responder.
module tb_cdc_hs_tx;
  logic clk = 0, rst = 0, in_valid = 0, ack_in = 0;
  logic [3:0] in_data = 0;
  logic in_ready, req_out, done, stall;
  logic [3:0] data_out;
  int n_chk = 0, n_pass = 0, n_fail = 0, n_hs = 0;
  logic [3:0] sb[$];
  logic [3:0] last = 0;

  cdc_hs_tx #(.width(4), .timeout(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_out(req_out), .data_out(data_out), .ack_in(ack_in), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n = 0;
    while (req_out !== v && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(req_out), 32'(v));
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1;
    in_data = d;
    sb.push_back(d);
    tick();
    in_valid = 0;
  endtask

  task automatic far_req();
    wait_req(1'b1, "req_rise");
    n_hs++;
    if (sb.size() > 0) begin
      last = sb.pop_front();
      chk("far_data", 32'(data_out), 32'(last));
    end else chk("far_data_unexpected", 32'(data_out), 32'hDEAD);
  endtask

  task automatic far_rel();
    int n = 0;
    wait_req(1'b0, "req_fall");
    ack_in = 0;
    while (done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk("done", 32'(done), 32'd1);
    chk("ready_at_done", 32'(in_ready), 32'd0);
    chk("data_hold", 32'(data_out), 32'(last));
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic far_ack(input int dly);
    repeat (dly) tick();
    ack_in = 1;
    far_rel();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int extra;
    #1 rst = 1;
    #2;
    chk("rst_req", 32'(req_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst = 0;
    // single transfer with exact latencies
    chk("t1_ready", 32'(in_ready), 32'd1);
    send(4'hA);
    chk("t1_data_e0", 32'(data_out), 32'hA);
    chk("t1_req_e0", 32'(req_out), 32'd0);
    chk("t1_ready_setup", 32'(in_ready), 32'd0);
    tick();
    chk("t1_req_e1", 32'(req_out), 32'd0);
    tick();
    chk("t1_req_e2", 32'(req_out), 32'd1);
    n_hs++;
    last = sb.pop_front();
    chk("t1_far_data", 32'(data_out), 32'(last));
    repeat (3) tick();
    ack_in = 1;
    tick();
    chk("t1_req_ack1", 32'(req_out), 32'd1);
    tick();
    chk("t1_req_ack2", 32'(req_out), 32'd1);
    tick();
    chk("t1_req_ack3", 32'(req_out), 32'd0);
    far_rel();
    // back-to-back with in_valid held
    in_valid = 1;
    in_data = 4'h3;
    sb.push_back(4'h3);
    tick();
    in_data = 4'hC;
    sb.push_back(4'hC);
    far_req();
    far_ack(3);
    chk("b2b_ready_after_done", 32'(in_ready), 32'd1);
    chk("b2b_data_still3", 32'(data_out), 32'h3);
    tick();
    in_valid = 0;
    chk("b2b_data_c", 32'(data_out), 32'hC);
    far_req();
    far_ack(3);
    extra = 0;
    repeat (6) begin
      tick();
      if (req_out) extra++;
    end
    chk("b2b_no_dup", 32'(extra), 32'd0);
    chk("b2b_hs_count", 32'(n_hs), 32'd3);
    // busy ignore
    send(4'h6);
    far_req();
    chk("busy_ready", 32'(in_ready), 32'd0);
    in_valid = 1;
    in_data = 4'h5;
    tick();
    in_valid = 0;
    chk("busy_data", 32'(data_out), 32'h6);
    far_ack(3);
    extra = 0;
    repeat (6) begin
      tick();
      if (req_out) extra++;
    end
    chk("busy_no_req", 32'(extra), 32'd0);
    chk("busy_data_after", 32'(data_out), 32'h6);
    chk("busy_sb_empty", 32'(sb.size()), 32'd0);
    // stall after 8 cycles in REQ, cleared on REQ->REL
    send(4'h9);
    far_req();
    repeat (6) tick();
    chk("to_stall_e8", 32'(stall), 32'd0);
    tick();
    chk("to_stall_e9", 32'(stall), 32'd1);
    ack_in = 1;
    tick();
    tick();
    chk("to_stall_held", 32'(stall), 32'd1);
    chk("to_req_held", 32'(req_out), 32'd1);
    tick();
    chk("to_stall_clear", 32'(stall), 32'd0);
    chk("to_req_fall", 32'(req_out), 32'd0);
    far_rel();
    // async reset during REQ with ack high
    send(4'h7);
    far_req();
    ack_in = 1;
    #3 rst = 1;
    #1;
    chk("ar_req", 32'(req_out), 32'd0);
    chk("ar_data", 32'(data_out), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_stall", 32'(stall), 32'd0);
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    chk("ar_ready_ack_high", 32'(in_ready), 32'd0);
    ack_in = 0;
    tick();
    chk("ar_ready_1edge", 32'(in_ready), 32'd0);
    tick();
    chk("ar_ready_2edge", 32'(in_ready), 32'd1);
    send(4'hF);
    far_req();
    far_ack(3);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
